acc_backend_adapter: RTL and testbench
======================================

ACC_BACKEND_ADAPTER -- requirements
Module: acc_backend_adapter

Interface
REQ-001 SHALL have parameter ReqDepth, default 2, input request FIFO depth (>=1).
REQ-002 SHALL have parameter MaxOutstanding, default 4, in-flight instruction limit (power of 2, >=2).
REQ-003 SHALL have parameter TransIdBits, default 3, transaction ID width.
REQ-004 SHALL have parameter XLEN, default 64, operand/result width.
REQ-005 SHALL have port clk_i  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port rst_ni  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports req_valid_i in 1 / req_ready_o out 1  dispatcher request handshake.
REQ-008 SHALL have ports req_insn_i in 32, req_rs1_i in XLEN, req_rs2_i in XLEN, req_trans_id_i in TransIdBits  request payload.
REQ-009 SHALL have ports be_valid_o out 1 / be_ready_i in 1, plus be_insn_o out 32, be_rs1_o out XLEN, be_rs2_o out XLEN  backend issue.
REQ-010 SHALL have ports be_done_valid_i in 1 / be_done_ready_o out 1, be_result_i in XLEN, be_error_i in 1  in-order backend completion.
REQ-011 SHALL have ports resp_valid_o out 1 / resp_ready_i in 1, resp_trans_id_o out TransIdBits, resp_result_o out XLEN, resp_exception_o out 1  response to dispatcher.
REQ-012 SHALL have ports load_complete_o out 1, store_complete_o out 1, store_pending_o out 1, protocol_err_o out 1  memory tracking/status.

Function
REQ-013 Request classification: insn[6:0]==7'b0000111 -> load; 7'b0100111 -> store; else compute.
REQ-014 Input FIFO: registered (no fall-through), depth ReqDepth; req_ready_o = !full; push on req_valid_i && req_ready_o.
REQ-015 Simultaneous push and pop on full FIFO SHALL be refused push (req_ready_o low while full).
REQ-016 be_valid_o = FIFO non-empty && outstanding < MaxOutstanding; be_* payload = FIFO head; pop on be_valid_o && be_ready_i.
REQ-017 be_valid_o once asserted SHALL hold with stable payload until be_ready_i (outstanding only grows via issue, so condition cannot drop).
REQ-018 On issue handshake, {trans_id, kind} SHALL be pushed into in-flight queue (depth MaxOutstanding); outstanding counter +1.
REQ-019 Completion: be_done_ready_o = in-flight non-empty && (!resp_valid_o || resp_ready_i); on handshake, pop in-flight head, load response register (trans_id, be_result_i, be_error_i) in the same edge.
REQ-020 Issue and completion in the same cycle SHALL leave outstanding unchanged; counter never wraps.
REQ-021 Response register: resp_valid_o set on completion handshake, cleared on resp_ready_i without new completion; back-to-back completions at 1/cycle when resp_ready_i held high.
REQ-022 Latency: request accepted cycle N -> earliest be_valid_o cycle N+1; completion cycle M -> resp_valid_o cycle M+1.
REQ-023 load_complete_o / store_complete_o SHALL pulse high exactly one cycle, registered, the cycle after completion handshake of a load/store entry.
REQ-024 store_pending_o SHALL be high while any store sits in input FIFO or in-flight queue (combinational from occupancy counters).
REQ-025 be_done_valid_i while in-flight queue empty SHALL be ignored (be_done_ready_o low) and SHALL set sticky protocol_err_o.
REQ-026 resp_exception_o = be_error_i captured with the completion; exceptions do not alter ordering or counts.

Reset
REQ-027 While rst_ni low at a clock edge: FIFO and in-flight queue empty, outstanding=0, resp_valid_o=0, load/store_complete_o=0, protocol_err_o=0.
REQ-028 After reset: req_ready_o=1, be_valid_o=0, be_done_ready_o=0, store_pending_o=0; reset mid-operation discards all entries without emitting responses.

Verification
REQ-029 One compute insn, trans_id 5, be_ready_i=1, done 3 cycles later result 0xABCD -> resp_valid_o one cycle after done, trans_id 5, result 0xABCD, exception 0.
REQ-030 be_ready_i=1, done never returned, stream 6 requests -> exactly 4 backend issues, then be_valid_o=0, req_ready_o=0 after FIFO fills (2 more).
REQ-031 Store insn (opcode 0x27) issued, completed -> store_pending_o high from accept cycle until completion, store_complete_o single pulse, load_complete_o stays 0.
REQ-032 Two completions back-to-back with resp_ready_i low -> first held, be_done_ready_o low on second until resp_ready_i pulses; trans_ids returned in issue order.
REQ-033 be_done_valid_i with nothing in flight -> protocol_err_o=1 and stays 1 until reset; rst_ni low mid-stream -> all outputs at REQ-027/028 values next cycle.

Source files
------------

// File: rtl/acc_backend_adapter.sv
// Accelerator backend adapter: request FIFO, in-order in-flight tracking,
// response register and load/store completion status.
module acc_backend_adapter #(
    parameter int ReqDepth       = 2,
    parameter int MaxOutstanding = 4,
    parameter int TransIdBits    = 3,
    parameter int XLEN           = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [31:0]            req_insn_i,
    input  logic [XLEN-1:0]        req_rs1_i,
    input  logic [XLEN-1:0]        req_rs2_i,
    input  logic [TransIdBits-1:0] req_trans_id_i,
    output logic                   be_valid_o,
    input  logic                   be_ready_i,
    output logic [31:0]            be_insn_o,
    output logic [XLEN-1:0]        be_rs1_o,
    output logic [XLEN-1:0]        be_rs2_o,
    input  logic                   be_done_valid_i,
    output logic                   be_done_ready_o,
    input  logic [XLEN-1:0]        be_result_i,
    input  logic                   be_error_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [TransIdBits-1:0] resp_trans_id_o,
    output logic [XLEN-1:0]        resp_result_o,
    output logic                   resp_exception_o,
    output logic                   load_complete_o,
    output logic                   store_complete_o,
    output logic                   store_pending_o,
    output logic                   protocol_err_o
);

    localparam int FPW = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
    localparam int FCW = $clog2(ReqDepth + 1);
    localparam int QPW = $clog2(MaxOutstanding);
    localparam int QCW = QPW + 1;

    localparam logic [FCW-1:0] FifoFull  = FCW'(ReqDepth);
    localparam logic [FPW-1:0] FifoLast  = FPW'(ReqDepth - 1);
    localparam logic [QCW-1:0] QueueFull = QCW'(MaxOutstanding);

    localparam logic [1:0] KindCompute = 2'd0;
    localparam logic [1:0] KindLoad    = 2'd1;
    localparam logic [1:0] KindStore   = 2'd2;

    function automatic logic [1:0] classify(input logic [31:0] insn);
        logic [1:0] kind;
        kind = KindCompute;
        if (insn[6:0] == 7'b0000111) kind = KindLoad;
        if (insn[6:0] == 7'b0100111) kind = KindStore;
        return kind;
    endfunction

    logic [31:0]            f_insn [ReqDepth];
    logic [XLEN-1:0]        f_rs1  [ReqDepth];
    logic [XLEN-1:0]        f_rs2  [ReqDepth];
    logic [TransIdBits-1:0] f_tid  [ReqDepth];
    logic [FPW-1:0]         f_wr;
    logic [FPW-1:0]         f_rd;
    logic [FCW-1:0]         f_cnt;

    logic [TransIdBits-1:0] q_tid  [MaxOutstanding];
    logic [1:0]             q_kind [MaxOutstanding];
    logic [QPW-1:0]         q_wr;
    logic [QPW-1:0]         q_rd;
    logic [QCW-1:0]         q_cnt;

    logic [FCW-1:0] st_fifo;
    logic [QCW-1:0] st_queue;

    logic       push;
    logic       issue;
    logic       done;
    logic [1:0] req_kind;
    logic [1:0] head_kind;
    logic [1:0] done_kind;
    logic       push_st;
    logic       issue_st;
    logic       done_st;

    assign req_kind  = classify(req_insn_i);
    assign head_kind = classify(f_insn[f_rd]);
    assign done_kind = q_kind[q_rd];

    assign req_ready_o = (f_cnt != FifoFull);
    assign push        = req_valid_i && req_ready_o;

    // Issue stalls only on outstanding limit, which cannot drop before issue.
    assign be_valid_o = (f_cnt != '0) && (q_cnt < QueueFull);
    assign be_insn_o  = f_insn[f_rd];
    assign be_rs1_o   = f_rs1[f_rd];
    assign be_rs2_o   = f_rs2[f_rd];
    assign issue      = be_valid_o && be_ready_i;

    assign be_done_ready_o = (q_cnt != '0) && (!resp_valid_o || resp_ready_i);
    assign done            = be_done_valid_i && be_done_ready_o;

    assign push_st  = push && (req_kind == KindStore);
    assign issue_st = issue && (head_kind == KindStore);
    assign done_st  = done && (done_kind == KindStore);

    assign store_pending_o = (st_fifo != '0) || (st_queue != '0);

    always_ff @(posedge clk_i) begin
        if (push) begin
            f_insn[f_wr] <= req_insn_i;
            f_rs1[f_wr]  <= req_rs1_i;
            f_rs2[f_wr]  <= req_rs2_i;
            f_tid[f_wr]  <= req_trans_id_i;
        end
        if (issue) begin
            q_tid[q_wr]  <= f_tid[f_rd];
            q_kind[q_wr] <= head_kind;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            f_wr  <= '0;
            f_rd  <= '0;
            f_cnt <= '0;
        end else begin
            if (push) f_wr <= (f_wr == FifoLast) ? '0 : f_wr + 1'b1;
            if (issue) f_rd <= (f_rd == FifoLast) ? '0 : f_rd + 1'b1;
            case ({push, issue})
                2'b10:   f_cnt <= f_cnt + 1'b1;
                2'b01:   f_cnt <= f_cnt - 1'b1;
                default: f_cnt <= f_cnt;
            endcase
        end
    end

    // q_cnt doubles as the outstanding counter.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_wr  <= '0;
            q_rd  <= '0;
            q_cnt <= '0;
        end else begin
            if (issue) q_wr <= q_wr + 1'b1;
            if (done) q_rd <= q_rd + 1'b1;
            case ({issue, done})
                2'b10:   q_cnt <= q_cnt + 1'b1;
                2'b01:   q_cnt <= q_cnt - 1'b1;
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            st_fifo  <= '0;
            st_queue <= '0;
        end else begin
            case ({push_st, issue_st})
                2'b10:   st_fifo <= st_fifo + 1'b1;
                2'b01:   st_fifo <= st_fifo - 1'b1;
                default: st_fifo <= st_fifo;
            endcase
            case ({issue_st, done_st})
                2'b10:   st_queue <= st_queue + 1'b1;
                2'b01:   st_queue <= st_queue - 1'b1;
                default: st_queue <= st_queue;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            resp_valid_o     <= 1'b0;
            resp_trans_id_o  <= '0;
            resp_result_o    <= '0;
            resp_exception_o <= 1'b0;
            load_complete_o  <= 1'b0;
            store_complete_o <= 1'b0;
            protocol_err_o   <= 1'b0;
        end else begin
            if (done) begin
                resp_valid_o     <= 1'b1;
                resp_trans_id_o  <= q_tid[q_rd];
                resp_result_o    <= be_result_i;
                resp_exception_o <= be_error_i;
            end else if (resp_ready_i) begin
                resp_valid_o <= 1'b0;
            end
            load_complete_o  <= done && (done_kind == KindLoad);
            store_complete_o <= done_st;
            if (be_done_valid_i && (q_cnt == '0)) protocol_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_acc_backend_adapter.sv
// Directed bench for acc_backend_adapter: per-cycle vector table
// plus hand-written sequences for limits, ordering, errors and reset.
module tb_acc_backend_adapter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam logic [31:0] CMP = 32'h0000_0033;
    localparam logic [31:0] ST  = 32'h0000_2027;
    localparam logic [31:0] LD  = 32'h0000_3007;
    localparam logic [31:0] OPH = 32'hA5A5_0000;

    typedef struct packed {
        logic        rst;
        logic        rv;
        logic [31:0] insn;
        logic [2:0]  tid;
        logic        br;
        logic        dv;
        logic [63:0] res;
        logic        err;
        logic        rr;
    } in_t;

    typedef struct packed {
        logic        rdy;
        logic        bv;
        logic [31:0] binsn;
        logic        ops;
        logic        ddr;
        logic        vld;
        logic [2:0]  rtid;
        logic [63:0] rres;
        logic        rexc;
        logic        lc;
        logic        sc;
        logic        sp;
        logic        pe;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_insn;
    logic [63:0] req_rs1, req_rs2;
    logic [2:0]  req_tid;
    logic        be_valid, be_ready;
    logic [31:0] be_insn;
    logic [63:0] be_rs1, be_rs2;
    logic        done_valid, done_ready;
    logic [63:0] be_result;
    logic        be_error;
    logic        resp_valid, resp_ready;
    logic [2:0]  resp_tid;
    logic [63:0] resp_result;
    logic        resp_exc;
    logic        load_c, store_c, store_p, perr;

    int tests = 0;
    int fails = 0;
    vec_t tv[$];

    always #5 clk = ~clk;

    assign req_rs1 = {OPH, req_insn};
    assign req_rs2 = ~{OPH, req_insn};

    acc_backend_adapter dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_insn_i      (req_insn),
        .req_rs1_i       (req_rs1),
        .req_rs2_i       (req_rs2),
        .req_trans_id_i  (req_tid),
        .be_valid_o      (be_valid),
        .be_ready_i      (be_ready),
        .be_insn_o       (be_insn),
        .be_rs1_o        (be_rs1),
        .be_rs2_o        (be_rs2),
        .be_done_valid_i (done_valid),
        .be_done_ready_o (done_ready),
        .be_result_i     (be_result),
        .be_error_i      (be_error),
        .resp_valid_o    (resp_valid),
        .resp_ready_i    (resp_ready),
        .resp_trans_id_o (resp_tid),
        .resp_result_o   (resp_result),
        .resp_exception_o(resp_exc),
        .load_complete_o (load_c),
        .store_complete_o(store_c),
        .store_pending_o (store_p),
        .protocol_err_o  (perr)
    );

    task automatic drive(input in_t i);
        rst_n      = i.rst;
        req_valid  = i.rv;
        req_insn   = i.insn;
        req_tid    = i.tid;
        be_ready   = i.br;
        done_valid = i.dv;
        be_result  = i.res;
        be_error   = i.err;
        resp_ready = i.rr;
    endtask

    function automatic out_t sample();
        out_t o;
        o.rdy   = req_ready;
        o.bv    = be_valid;
        o.binsn = be_valid ? be_insn : 32'h0;
        o.ops   = !be_valid ||
                  (be_rs1 == {OPH, be_insn} && be_rs2 == ~{OPH, be_insn});
        o.ddr   = done_ready;
        o.vld   = resp_valid;
        o.rtid  = resp_valid ? resp_tid : 3'd0;
        o.rres  = resp_valid ? resp_result : 64'h0;
        o.rexc  = resp_valid ? resp_exc : 1'b0;
        o.lc    = load_c;
        o.sc    = store_c;
        o.sp    = store_p;
        o.pe    = perr;
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input int row, input out_t exp);
        out_t act;
        act = sample();
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL row%0d: got %h, expected %h", row, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rst);
        drive('{rst, L, 32'h0, 3'd0, L, L, 64'h0, L, L});
    endtask

    task automatic do_reset();
        idle(L);
        next_cycle();
        next_cycle();
        idle(H);
    endtask

    task automatic push_one(input logic [31:0] insn, input logic [2:0] tid);
        req_valid = H;
        req_insn  = insn;
        req_tid   = tid;
        next_cycle();
        req_valid = L;
        req_insn  = 32'h0;
    endtask

    task automatic seq_limit();
        int acc;
        int iss;
        acc = 0;
        iss = 0;
        do_reset();
        be_ready = H;
        for (int c = 0; c < 12; c++) begin
            req_valid = (acc < 6);
            req_insn  = CMP | (32'(c) << 12);
            req_tid   = 3'(c);
            @(negedge clk);
            if (req_valid && req_ready) acc++;
            if (be_valid && be_ready) iss++;
            next_cycle();
        end
        idle(H);
        be_ready = H;
        @(negedge clk);
        check("issues", 64'(iss), 64'd4);
        check("accepted", 64'(acc), 64'd6);
        check("limit_be_valid", 64'(be_valid), 64'd0);
        check("full_req_ready", 64'(req_ready), 64'd0);
        next_cycle();
    endtask

    task automatic seq_order();
        do_reset();
        be_ready = H;
        push_one(CMP, 3'd1);
        push_one(CMP, 3'd6);
        next_cycle();
        done_valid = H;
        be_result  = 64'hA;
        @(negedge clk);
        check("first_done_ready", 64'(done_ready), 64'd1);
        next_cycle();
        be_result = 64'hB;
        @(negedge clk);
        check("held_done_ready", 64'(done_ready), 64'd0);
        check("held_tid", 64'(resp_tid), 64'd1);
        check("held_result", resp_result, 64'hA);
        next_cycle();
        @(negedge clk);
        check("still_held", {63'd0, resp_valid}, 64'd1);
        check("still_blocked", 64'(done_ready), 64'd0);
        next_cycle();
        resp_ready = H;
        @(negedge clk);
        check("release_done_ready", 64'(done_ready), 64'd1);
        next_cycle();
        done_valid = L;
        @(negedge clk);
        check("second_valid", 64'(resp_valid), 64'd1);
        check("second_tid", 64'(resp_tid), 64'd6);
        check("second_result", resp_result, 64'hB);
        next_cycle();
        @(negedge clk);
        check("drained_valid", 64'(resp_valid), 64'd0);
        next_cycle();
    endtask

    task automatic seq_error_reset();
        do_reset();
        done_valid = H;
        @(negedge clk);
        check("empty_done_ready", 64'(done_ready), 64'd0);
        next_cycle();
        done_valid = L;
        @(negedge clk);
        check("perr_set", 64'(perr), 64'd1);
        check("perr_no_resp", 64'(resp_valid), 64'd0);
        next_cycle();
        be_ready = H;
        push_one(ST, 3'd4);
        push_one(CMP, 3'd2);
        be_ready = L;
        push_one(ST, 3'd3);
        @(negedge clk);
        check("perr_sticky", 64'(perr), 64'd1);
        check("mid_pending", 64'(store_p), 64'd1);
        check("mid_inflight", 64'(done_ready), 64'd1);
        next_cycle();
        idle(L);
        next_cycle();
        idle(H);
        done_valid = L;
        @(negedge clk);
        check("rst_out", {58'd0, req_ready, be_valid, done_ready,
                          resp_valid, store_p, perr}, 64'b100000);
        check("rst_pulses", {62'd0, load_c, store_c}, 64'd0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_no_resp", 64'(resp_valid), 64'd0);
        next_cycle();
    endtask

    initial begin
        // in: rst rv insn tid br dv res err rr
        // out: rdy bv binsn ops ddr vld rtid rres rexc lc sc sp pe
        tv.push_back('{'{L, L, 32'h0, 3'd0, L, L, 64'h0, L, L},
            '{H, L, 32'h0, H, L, L, 3'd0, 64'h0, L, L, L, L, L}});
        tv.push_back('{'{H, H, CMP, 3'd5, H, L, 64'h0, L, L},
            '{H, L, 32'h0, H, L, L, 3'd0, 64'h0, L, L, L, L, L}});
        tv.push_back('{'{H, L, 32'h0, 3'd0, H, L, 64'h0, L, L},
            '{H, H, CMP, H, L, L, 3'd0, 64'h0, L, L, L, L, L}});
        tv.push_back('{'{H, L, 32'h0, 3'd0, H, L, 64'h0, L, L},
            '{H, L, 32'h0, H, H, L, 3'd0, 64'h0, L, L, L, L, L}});
        tv.push_back('{'{H, L, 32'h0, 3'd0, H, L, 64'h0, L, L},
            '{H, L, 32'h0, H, H, L, 3'd0, 64'h0, L, L, L, L, L}});
        tv.push_back('{'{H, L, 32'h0, 3'd0, H, H, 64'hABCD, L, H},
            '{H, L, 32'h0, H, H, L, 3'd0, 64'h0, L, L, L, L, L}});
        tv.push_back('{'{H, L, 32'h0, 3'd0, H, L, 64'h0, L, H},
            '{H, L, 32'h0, H, L, H, 3'd5, 64'hABCD, L, L, L, L, L}});
        tv.push_back('{'{H, L, 32'h0, 3'd0, L, L, 64'h0, L, L},
            '{H, L, 32'h0, H, L, L, 3'd0, 64'h0, L, L, L, L, L}});
        tv.push_back('{'{H, H, ST, 3'd2, L, L, 64'h0, L, L},
            '{H, L, 32'h0, H, L, L, 3'd0, 64'h0, L, L, L, L, L}});
        tv.push_back('{'{H, L, 32'h0, 3'd0, L, L, 64'h0, L, L},
            '{H, H, ST, H, L, L, 3'd0, 64'h0, L, L, L, H, L}});
        tv.push_back('{'{H, L, 32'h0, 3'd0, H, L, 64'h0, L, L},
            '{H, H, ST, H, L, L, 3'd0, 64'h0, L, L, L, H, L}});
        tv.push_back('{'{H, L, 32'h0, 3'd0, L, H, 64'h11, H, H},
            '{H, L, 32'h0, H, H, L, 3'd0, 64'h0, L, L, L, H, L}});
        tv.push_back('{'{H, L, 32'h0, 3'd0, L, L, 64'h0, L, H},
            '{H, L, 32'h0, H, L, H, 3'd2, 64'h11, H, L, H, L, L}});
        tv.push_back('{'{H, L, 32'h0, 3'd0, L, L, 64'h0, L, L},
            '{H, L, 32'h0, H, L, L, 3'd0, 64'h0, L, L, L, L, L}});
        tv.push_back('{'{H, H, LD, 3'd3, H, L, 64'h0, L, L},
            '{H, L, 32'h0, H, L, L, 3'd0, 64'h0, L, L, L, L, L}});
        tv.push_back('{'{H, L, 32'h0, 3'd0, H, L, 64'h0, L, L},
            '{H, H, LD, H, L, L, 3'd0, 64'h0, L, L, L, L, L}});
        tv.push_back('{'{H, L, 32'h0, 3'd0, L, H, 64'h22, L, L},
            '{H, L, 32'h0, H, H, L, 3'd0, 64'h0, L, L, L, L, L}});
        tv.push_back('{'{H, L, 32'h0, 3'd0, L, L, 64'h0, L, L},
            '{H, L, 32'h0, H, L, H, 3'd3, 64'h22, L, H, L, L, L}});
        tv.push_back('{'{H, L, 32'h0, 3'd0, L, L, 64'h0, L, H},
            '{H, L, 32'h0, H, L, H, 3'd3, 64'h22, L, L, L, L, L}});
        tv.push_back('{'{H, L, 32'h0, 3'd0, L, L, 64'h0, L, L},
            '{H, L, 32'h0, H, L, L, 3'd0, 64'h0, L, L, L, L, L}});

        idle(L);
        next_cycle();
        next_cycle();
        foreach (tv[k]) begin
            drive(tv[k].i);
            @(negedge clk);
            check_out(k, tv[k].o);
            next_cycle();
        end

        seq_limit();
        seq_order();
        seq_error_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
